fifo_burst_reader: RTL

Read-side controller for the single-clock register-array FIFO. It watches FIFO occupancy and drains words in fixed-length bursts onto a downstream valid/ready stream, with first/last markers. It sits between the FIFO read port and the downstream consumer, and it is the only agent that asserts the FIFO read enable. Partial bursts are released by an explicit flush or, optionally, by an idle timeout.

---
 rtl/fifo_burst_reader.sv | 204 ++++++++++++++++++++
 1 files changed

// File: rtl/fifo_burst_reader.sv
// ---------------------------------------------------------------------------
// fifo_burst_reader
// Read-side controller for the single-clock register-array FIFO. Watches FIFO
// occupancy and drains words in fixed-length bursts onto a valid/ready stream
// with first/last markers. It is the only agent driving the FIFO read enable.
// Partial bursts are released by flush or, optionally, by an idle timeout.
//
// Optional feature macro: FIFO_RD_TIMEOUT_EN
//   defined   : idle-timeout counter compiled in; a partial occupancy held for
//               TIMEOUT_CYCLES idle cycles starts a burst exactly like flush.
//   undefined : no timeout logic; partial occupancy waits for flush.
//
// Ports:
//   clk          clock, rising edge
//   reset        asynchronous, active-high reset
//   fifo_data    FIFO head word (first-word-fall-through)
//   fifo_empty   FIFO empty flag
//   fifo_depth   FIFO occupancy, 0..2**ADDR_WIDTH
//   fifo_ren     FIFO read enable (combinational)
//   flush        level; while high a partial burst may start
//   m_data       output word (registered)
//   m_valid      m_data is valid
//   m_ready      downstream accepts the word
//   m_first      m_data is the first word of a burst
//   m_last       m_data is the last word of a burst
//   busy         controller is in a burst
//   burst_count  bursts fully read from the FIFO, wraps modulo 2**16
// ---------------------------------------------------------------------------
module fifo_burst_reader #(
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned BURST_LEN      = 4,
    parameter int unsigned TIMEOUT_CYCLES = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    input  logic                  fifo_empty,
    input  logic [ADDR_WIDTH:0]   fifo_depth,
    output logic                  fifo_ren,
    input  logic                  flush,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_first,
    output logic                  m_last,
    output logic                  busy,
    output logic [15:0]           burst_count
);

    localparam int unsigned CNT_W   = $clog2(BURST_LEN) + 1;
    localparam int unsigned DEPTH_W = ADDR_WIDTH + 1;
    localparam int unsigned BCNT_W  = 16;
    localparam logic [DEPTH_W-1:0] BURST_DEPTH = DEPTH_W'(BURST_LEN);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [CNT_W-1:0]        len_q, len_d;
    logic [CNT_W-1:0]        idx_q, idx_d;
    logic [DATA_WIDTH-1:0]   m_data_q, m_data_d;
    logic                    m_valid_q, m_valid_d;
    logic                    m_first_q, m_first_d;
    logic                    m_last_q, m_last_d;
    logic [BCNT_W-1:0]       burst_count_q, burst_count_d;

    logic full_c;
    logic partial_c;
    logic timeout_c;
    logic start_c;
    logic last_rd_c;

    // Burst start qualification; a full burst takes priority over flush/timeout.
    always_comb begin
        full_c    = (fifo_depth >= BURST_DEPTH);
        partial_c = (fifo_depth != '0) && !full_c;
        start_c   = (state_q == ST_IDLE) &&
                    (full_c || (partial_c && (flush || timeout_c)));
    end

`ifdef FIFO_RD_TIMEOUT_EN
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

    logic [TMO_W-1:0] tmo_q, tmo_d;

    // Counts consecutive idle cycles holding a partial burst; saturates at max.
    always_comb begin
        tmo_d = '0;
        if ((state_q == ST_IDLE) && partial_c && !start_c) begin
            tmo_d = (tmo_q == TMO_MAX) ? tmo_q : tmo_q + TMO_W'(1);
        end
    end

    assign timeout_c = (tmo_q == TMO_MAX);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_q <= '0;
        end else begin
            tmo_q <= tmo_d;
        end
    end
`else
    logic [31:0] unused_timeout;

    assign timeout_c      = 1'b0;
    assign unused_timeout = 32'(TIMEOUT_CYCLES);
`endif

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: leave the burst on the read of its final word.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start_c)   state_d = ST_BURST;
            ST_BURST: if (last_rd_c) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // FSM outputs: read only when a word is owed and the output slot frees up.
    always_comb begin
        busy     = 1'b0;
        fifo_ren = 1'b0;
        busy     = (state_q == ST_BURST);
        fifo_ren = busy && !fifo_empty && (idx_q < len_q) &&
                   (!m_valid_q || m_ready);
    end

    assign last_rd_c = fifo_ren && (idx_q == len_q - CNT_W'(1));

    // Burst counters, output stage and completed-burst counter.
    always_comb begin
        len_d         = len_q;
        idx_d         = idx_q;
        m_data_d      = m_data_q;
        m_valid_d     = m_valid_q;
        m_first_d     = m_first_q;
        m_last_d      = m_last_q;
        burst_count_d = burst_count_q;

        if (start_c) begin
            // Partial depth is below BURST_LEN, so it fits the counter width.
            len_d = full_c ? CNT_W'(BURST_LEN) : CNT_W'(fifo_depth);
            idx_d = '0;
        end

        if (fifo_ren) begin
            m_data_d  = fifo_data;
            m_valid_d = 1'b1;
            m_first_d = (idx_q == '0);
            m_last_d  = (idx_q == len_q - CNT_W'(1));
            idx_d     = idx_q + CNT_W'(1);
        end else if (m_valid_q && m_ready) begin
            m_valid_d = 1'b0;
            m_first_d = 1'b0;
            m_last_d  = 1'b0;
        end

        if (last_rd_c) begin
            burst_count_d = burst_count_q + BCNT_W'(1);
        end
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len_q         <= '0;
            idx_q         <= '0;
            m_data_q      <= '0;
            m_valid_q     <= 1'b0;
            m_first_q     <= 1'b0;
            m_last_q      <= 1'b0;
            burst_count_q <= '0;
        end else begin
            len_q         <= len_d;
            idx_q         <= idx_d;
            m_data_q      <= m_data_d;
            m_valid_q     <= m_valid_d;
            m_first_q     <= m_first_d;
            m_last_q      <= m_last_d;
            burst_count_q <= burst_count_d;
        end
    end

    assign m_data      = m_data_q;
    assign m_valid     = m_valid_q;
    assign m_first     = m_first_q;
    assign m_last      = m_last_q;
    assign burst_count = burst_count_q;

endmodule
